// File: rtl/collision_scheduler.sv
// Time-multiplexed frog/car overlap checker: snapshots positions on a frame start and scans one lane per clock.
// Optional COLLISION_STICKY_EN makes the collision result set-only until i_Clear.
module collision_scheduler #(
    parameter int                     TILE_SIZE = 32,
    parameter int                     NUM_LANES = 6,
    parameter logic [9*NUM_LANES-1:0] LANE_Y    = {9'd352, 9'd320, 9'd288, 9'd160, 9'd128, 9'd96}
) (
    input  logic                    i_Clk,
    input  logic                    i_Reset,
    input  logic                    i_Frame_Start,
    input  logic [9:0]              i_Frog_X,
    input  logic [8:0]              i_Frog_Y,
    input  logic [10*NUM_LANES-1:0] i_Car_X,
    input  logic                    i_Clear,
    output logic                    o_Busy,
    output logic                    o_Scan_Done,
    output logic                    o_Has_Collided,
    output logic [2:0]              o_Hit_Lane
);

    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_SCAN   = 2'd1;
    localparam logic [1:0]  ST_DONE   = 2'd2;
    localparam logic [2:0]  LAST_LANE = 3'(NUM_LANES - 1);
    localparam logic [10:0] TILE      = 11'(TILE_SIZE);

    logic [1:0]              state_q, state_d;
    logic [2:0]              lane_cnt_q, lane_cnt_d;
    logic                    pending_q, pending_d;
    logic [9:0]              frog_x_q, frog_x_d;
    logic [8:0]              frog_y_q, frog_y_d;
    logic [10*NUM_LANES-1:0] car_x_q, car_x_d;
    logic                    acc_hit_q, acc_hit_d;
    logic [2:0]              acc_lane_q, acc_lane_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    has_q, has_d;
    logic [2:0]              hit_lane_q, hit_lane_d;

    logic [9:0]  sel_car_x;
    logic [8:0]  sel_lane_y;
    logic [10:0] fx_w, cx_w, fy_w, ly_w;
    logic        lane_hit;
    logic        take_snap;

    always_comb begin
        sel_car_x  = '0;
        sel_lane_y = '0;
        for (int n = 0; n < NUM_LANES; n++) begin
            if (lane_cnt_q == 3'(n)) begin
                sel_car_x  = car_x_q[10*n +: 10];
                sel_lane_y = LANE_Y[9*n +: 9];
            end
        end
    end

    // Widened to 11 bits so X+TILE near the right screen edge cannot wrap.
    assign fx_w = {1'b0, frog_x_q};
    assign cx_w = {1'b0, sel_car_x};
    assign fy_w = {2'b00, frog_y_q};
    assign ly_w = {2'b00, sel_lane_y};
    assign lane_hit = (fx_w < cx_w + TILE) && (cx_w < fx_w + TILE) &&
                      (fy_w < ly_w + TILE) && (ly_w < fy_w + TILE);

    always_comb begin
        state_d    = state_q;
        lane_cnt_d = lane_cnt_q;
        pending_d  = pending_q;
        frog_x_d   = frog_x_q;
        frog_y_d   = frog_y_q;
        car_x_d    = car_x_q;
        acc_hit_d  = acc_hit_q;
        acc_lane_d = acc_lane_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        has_d      = has_q;
        hit_lane_d = hit_lane_q;
        take_snap  = 1'b0;

`ifdef COLLISION_STICKY_EN
        if (i_Clear) begin
            has_d      = 1'b0;
            hit_lane_d = 3'd0;
        end
`endif

        case (state_q)
            ST_IDLE: begin
                if (i_Frame_Start) begin
                    take_snap = 1'b1;
                    state_d   = ST_SCAN;
                    busy_d    = 1'b1;
                end
            end
            ST_SCAN: begin
                if (i_Frame_Start) pending_d = 1'b1;
                if (lane_hit && !acc_hit_q) begin
                    acc_hit_d  = 1'b1;
                    acc_lane_d = lane_cnt_q;
                end
                if (lane_cnt_q == LAST_LANE) state_d = ST_DONE;
                else                         lane_cnt_d = lane_cnt_q + 3'd1;
            end
            ST_DONE: begin
                done_d = 1'b1;
`ifdef COLLISION_STICKY_EN
                if (acc_hit_q && !has_d) begin
                    has_d      = 1'b1;
                    hit_lane_d = acc_lane_q;
                end
`else
                has_d      = acc_hit_q;
                hit_lane_d = acc_lane_q;
`endif
                // A request seen during the scan (or on this edge) restarts without an idle cycle.
                if (pending_q || i_Frame_Start) begin
                    take_snap = 1'b1;
                    pending_d = 1'b0;
                    state_d   = ST_SCAN;
                    busy_d    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (take_snap) begin
            frog_x_d   = i_Frog_X;
            frog_y_d   = i_Frog_Y;
            car_x_d    = i_Car_X;
            lane_cnt_d = 3'd0;
            acc_hit_d  = 1'b0;
            acc_lane_d = 3'd0;
        end
    end

`ifndef COLLISION_STICKY_EN
    logic unused_clear;
    assign unused_clear = i_Clear;
`endif

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q    <= ST_IDLE;
            lane_cnt_q <= 3'd0;
            pending_q  <= 1'b0;
            frog_x_q   <= '0;
            frog_y_q   <= '0;
            car_x_q    <= '0;
            acc_hit_q  <= 1'b0;
            acc_lane_q <= 3'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            has_q      <= 1'b0;
            hit_lane_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            lane_cnt_q <= lane_cnt_d;
            pending_q  <= pending_d;
            frog_x_q   <= frog_x_d;
            frog_y_q   <= frog_y_d;
            car_x_q    <= car_x_d;
            acc_hit_q  <= acc_hit_d;
            acc_lane_q <= acc_lane_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            has_q      <= has_d;
            hit_lane_q <= hit_lane_d;
        end
    end

    assign o_Busy         = busy_q;
    assign o_Scan_Done    = done_q;
    assign o_Has_Collided = has_q;
    assign o_Hit_Lane     = hit_lane_q;

endmodule

// File: tb/tb_collision_scheduler.sv
// Randomized and directed bench for collision_scheduler against a lane-list reference model.
module tb_collision_scheduler;

    localparam int NL = 6;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            clr;
    logic [9:0]      fx;
    logic [8:0]      fy;
    logic [10*NL-1:0] car;
    logic            busy, done, has;
    logic [2:0]      lane;

    int checks   = 0;
    int failures = 0;
    int lane_y_tab [NL] = '{96, 128, 160, 288, 320, 352};
    bit m_has;
    int m_lane;

    always #5 clk = ~clk;

    collision_scheduler #(.TILE_SIZE(32), .NUM_LANES(NL)) dut (
        .i_Clk          (clk),
        .i_Reset        (rst),
        .i_Frame_Start  (start),
        .i_Frog_X       (fx),
        .i_Frog_Y       (fy),
        .i_Car_X        (car),
        .i_Clear        (clr),
        .o_Busy         (busy),
        .o_Scan_Done    (done),
        .o_Has_Collided (has),
        .o_Hit_Lane     (lane)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [10*NL-1:0] cars_all(input int v);
        logic [10*NL-1:0] r;
        for (int n = 0; n < NL; n++) r[10*n +: 10] = 10'(v);
        return r;
    endfunction

    // Overlap of two 32-px squares with plain integer arithmetic; lowest hitting lane wins.
    function automatic void ref_scan(input int f_x, input int f_y, input logic [10*NL-1:0] cars,
                                     output bit hit, output int hl);
        int cx, ly;
        bit h;
        hit = 0;
        hl  = 0;
        for (int n = 0; n < NL; n++) begin
            cx = int'(cars[10*n +: 10]);
            ly = lane_y_tab[n];
            h  = (f_x < cx + 32) && (cx < f_x + 32) && (f_y < ly + 32) && (ly < f_y + 32);
            if (h && !hit) begin
                hit = 1;
                hl  = n;
            end
        end
    endfunction

    function automatic void model_done(input bit hit, input int hl);
`ifdef COLLISION_STICKY_EN
        if (hit && !m_has) begin
            m_has  = 1;
            m_lane = hl;
        end
`else
        m_has  = hit;
        m_lane = hl;
`endif
    endfunction

    task automatic check_outputs(input string tag);
        check_val({tag, "_has"}, 32'(has), 32'(m_has));
        check_val({tag, "_lane"}, 32'(lane), 32'(m_lane));
    endtask

    // One isolated scan; live inputs are scrambled right after the start edge.
    task automatic run_scan(input int f_x, input int f_y, input logic [10*NL-1:0] cars, input string tag);
        bit h;
        int hl;
        fx    = 10'(f_x);
        fy    = 9'(f_y);
        car   = cars;
        start = 1'b1;
        tick();
        start = 1'b0;
        ref_scan(f_x, f_y, cars, h, hl);
        check_val({tag, "_busy_start"}, 32'(busy), 32'd1);
        fx  = 10'($urandom);
        fy  = 9'($urandom);
        car = {$urandom, $urandom};
        for (int c = 1; c <= NL; c++) begin
            tick();
            check_val({tag, "_busy_scan"}, 32'(busy), 32'd1);
            check_val({tag, "_done_early"}, 32'(done), 32'd0);
        end
        tick();
        model_done(h, hl);
        check_val({tag, "_done"}, 32'(done), 32'd1);
        check_val({tag, "_busy_end"}, 32'(busy), 32'd0);
        check_outputs(tag);
        tick();
        check_val({tag, "_done_pulse"}, 32'(done), 32'd0);
        check_outputs({tag, "_hold"});
    endtask

    initial begin
        logic [10*NL-1:0] cv;
        bit h1, h2;
        int l1, l2, rx, ry, cx;

        rst = 1'b1; start = 1'b0; clr = 1'b0;
        fx = '0; fy = '0; car = '0;
        m_has = 0; m_lane = 0;
        tick();
        tick();
        check_val("reset_busy", 32'(busy), 32'd0);
        check_val("reset_done", 32'(done), 32'd0);
        check_outputs("reset");
        rst = 1'b0;
        tick();

        cv = cars_all(600); cv[9:0] = 10'd90;
        run_scan(100, 96, cv, "t1_hit_lane0");
        run_scan(122, 96, cv, "t2_touch_x");
        cv = cars_all(600); cv[9:0] = 10'd190; cv[19:10] = 10'd210;
        run_scan(200, 112, cv, "t3_straddle");
        cv[9:0] = 10'd600;
        run_scan(200, 112, cv, "t3_lane1");
        run_scan(50, 64, cars_all(50), "t4_touch_y");
        cv = cars_all(0); cv[9:0] = 10'd1020;
        run_scan(1000, 96, cv, "right_edge");
        cv = cars_all(700); cv[49:40] = 10'd300; cv[59:50] = 10'd310;
        run_scan(305, 340, cv, "lane4_5");

        // Clear input: ignored in the default build, zeroes sticky results otherwise.
        cv = cars_all(600); cv[9:0] = 10'd90;
        run_scan(100, 96, cv, "pre_clear");
        run_scan(100, 96, cars_all(600), "clean_after_hit");
        clr = 1'b1;
        tick();
        clr = 1'b0;
`ifdef COLLISION_STICKY_EN
        m_has = 0; m_lane = 0;
`endif
        check_outputs("clear");

        // Back-to-back: extra requests at +3 and +4 yield exactly one more scan.
        fx = 10'd100; fy = 9'd96; car = cars_all(600); car[9:0] = 10'd90;
        start = 1'b1;
        tick();
        start = 1'b0;
        ref_scan(100, 96, car, h1, l1);
        h2 = 0; l2 = 0;
        for (int c = 1; c <= 18; c++) begin
            if (c == 2) car[9:0] = 10'd600;
            start = (c == 3 || c == 4);
            if (c == 7) ref_scan(int'(fx), int'(fy), car, h2, l2);
            tick();
            check_val("b2b_done", 32'(done), 32'((c == 7 || c == 14) ? 1 : 0));
            check_val("b2b_busy", 32'(busy), 32'((c < 14) ? 1 : 0));
            if (c == 7) begin
                model_done(h1, l1);
                check_outputs("b2b_first");
            end
            if (c == 14) begin
                model_done(h2, l2);
                check_outputs("b2b_second");
            end
        end
        start = 1'b0;

        // Reset mid-scan with a request pending: no done pulse afterwards.
        cv = cars_all(600); cv[9:0] = 10'd90;
        run_scan(100, 96, cv, "pre_reset");
        fx = 10'd100; fy = 9'd96; car = cv;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            start = (c == 2);
            tick();
        end
        start = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_has = 0; m_lane = 0;
        check_val("midreset_busy", 32'(busy), 32'd0);
        check_val("midreset_done", 32'(done), 32'd0);
        check_outputs("midreset");
        for (int c = 0; c < 12; c++) begin
            tick();
            check_val("postreset_done", 32'(done), 32'd0);
            check_val("postreset_busy", 32'(busy), 32'd0);
        end
        check_outputs("postreset");

        // Random positions, biased so cars often sit near the frog.
        for (int i = 0; i < 30; i++) begin
            rx = int'($urandom_range(0, 1023));
            ry = int'($urandom_range(60, 390));
            for (int n = 0; n < NL; n++) begin
                if ($urandom_range(0, 2) == 0) cx = int'($urandom_range(0, 1023));
                else begin
                    cx = rx - 40 + int'($urandom_range(0, 80));
                    if (cx < 0) cx = 0;
                    if (cx > 1023) cx = 1023;
                end
                cv[10*n +: 10] = 10'(cx);
            end
            run_scan(rx, ry, cv, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
